ksa_engine: RTL and testbench
=============================

KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning S-box address width; depth N = 2^ADDR_W, data width = ADDR_W.
REQ-002 SHALL have parameter KEY_BYTES, default 3, meaning key length in bytes; legal range 1..16.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, start request, sampled only while rdy=1.
REQ-007 SHALL have port skip_init, input, 1, sampled with en; 1 = skip identity-fill phase.
REQ-008 SHALL have port key, input, 8*KEY_BYTES, key; byte 0 = key[8*KEY_BYTES-1 -: 8].
REQ-009 SHALL have port rdy, output, 1, high when idle and able to accept en.
REQ-010 SHALL have port addr, output, ADDR_W, S-memory address.
REQ-011 SHALL have port rddata, input, ADDR_W, S-memory read data; valid one cycle after addr presented.
REQ-012 SHALL have port wrdata, output, ADDR_W, S-memory write data.
REQ-013 SHALL have port wren, output, 1, S-memory write enable.

Function
REQ-014 SHALL implement states IDLE, INIT, READ_I, READ_J, WRITE_I, WRITE_J.
REQ-015 IDLE: rdy=1, wren=0; on en=1 SHALL latch key and skip_init, drop rdy next cycle, and go to INIT (skip_init=0) or READ_I (skip_init=1), with i=0, j=0.
REQ-016 SHALL ignore en and key changes whenever rdy=0; latched key is used for the whole run.
REQ-017 INIT: one write per cycle, addr=i, wrdata=i, wren=1, for i=0..N-1; after i=N-1, i wraps to 0 and state goes to READ_I.
REQ-018 READ_I: addr=i, wren=0.
REQ-019 READ_J: capture si=rddata; j <= (j + si + keybyte[i mod KEY_BYTES]) mod N, keybyte zero-extended/truncated to ADDR_W bits; addr=new j, wren=0.
REQ-020 WRITE_I: addr=i, wrdata=rddata (s[j]), wren=1.
REQ-021 WRITE_J: addr=j, wrdata=si, wren=1; if i=N-1, go to IDLE; otherwise i increments, go to READ_I.
REQ-022 SHALL be correct when i=j; the WRITE_J write restores the original value.
REQ-023 Key index SHALL be a separate counter wrapping at KEY_BYTES-1, not a divider.
REQ-024 All arithmetic SHALL be modulo N; no overflow flags.
REQ-025 Latency from en-accept edge to rdy=1 SHALL be exactly N+4N+1 cycles (skip_init=0) or 4N+1 (skip_init=1); N=256 gives 1281 / 1025.
REQ-026 wren SHALL be 0 in IDLE, READ_I and READ_J.

Reset
REQ-027 While rst=1 at a clock edge SHALL go to IDLE: rdy=1, wren=0, addr=0, wrdata=0, i=j=0.
REQ-028 Reset mid-run SHALL abort immediately; memory contents are then unspecified.
REQ-029 rst and en high in the same cycle: reset wins; no run starts.

Verification
REQ-030 Reset then idle: rdy=1, wren=0, addr=0, wrdata=0 for 10 cycles with en=0.
REQ-031 Defaults, key=24'h00033C, skip_init=0: after 256 cycles mem[k]=k for all k; at rdy=1 (cycle 1281), mem[0]=8'hB4, mem[255]=8'h1B.
REQ-032 skip_init=1 on pre-filled identity memory, same key: identical final memory, rdy after 1025 cycles.
REQ-033 en pulses and key changes mid-run: final memory unchanged from REQ-031; rdy timing unchanged.
REQ-034 rst at cycle 600 of a run: rdy=1, wren=0 next cycle; a fresh run then gives REQ-031 values.
REQ-035 ADDR_W=4, KEY_BYTES=1 and ADDR_W=8, KEY_BYTES=16 with random keys: final memory matches a software RC4 KSA model; memory remains a permutation of 0..N-1.

Source files
------------

// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external synchronous S-box memory.
// Optionally identity-fills the memory, then performs N swap iterations
// j = j + S[i] + key[i mod KEY_BYTES] through a four-cycle read/read/write/write pattern.
module ksa_engine #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   skip_init,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   rdy,
    output logic [ADDR_W-1:0]      addr,
    input  logic [ADDR_W-1:0]      rddata,
    output logic [ADDR_W-1:0]      wrdata,
    output logic                   wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_I = '1;
    localparam logic [KW-1:0]     LAST_K = KW'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ_I,
        READ_J,
        WRITE_I,
        WRITE_J
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   j;
    logic [ADDR_W-1:0]   si;
    logic [ADDR_W-1:0]   j_sum;
    logic [ADDR_W-1:0]   key_ext;
    logic [KW-1:0]       kidx;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]          key_bytes [2**KW];
    logic                accept;

    // Byte 0 is the most significant key byte; padding entries are never selected.
    for (genvar b = 0; b < 2**KW; b++) begin : g_kb
        if (b < KEY_BYTES) begin : g_used
            assign key_bytes[b] = key_q[8*(KEY_BYTES-1-b) +: 8];
        end else begin : g_pad
            assign key_bytes[b] = '0;
        end
    end

    // Key byte is zero-extended or truncated to the S-box data width, so all sums wrap mod N.
    assign key_ext = ADDR_W'(key_bytes[kidx]);
    assign j_sum   = j + rddata + key_ext;
    assign accept  = (state == IDLE) && rdy && en;

    // State register and datapath registers; reset dominates any start request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            rdy   <= 1'b1;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            kidx  <= '0;
            key_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_q <= key;
                        i     <= '0;
                        j     <= '0;
                        kidx  <= '0;
                        rdy   <= 1'b0;
                    end else if (!rdy) begin
                        // One settling cycle in IDLE before accepting a new run.
                        rdy <= 1'b1;
                    end
                end
                INIT: begin
                    i <= i + 1'b1;
                end
                READ_J: begin
                    si <= rddata;
                    j  <= j_sum;
                end
                WRITE_J: begin
                    if (i != LAST_I) begin
                        i    <= i + 1'b1;
                        kidx <= (kidx == LAST_K) ? '0 : kidx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory-port decode for each phase of the schedule.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_n = state;
        addr    = '0;
        wrdata  = '0;
        wren    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = skip_init ? READ_I : INIT;
            end
            INIT: begin
                addr    = i;
                wrdata  = i;
                wren    = 1'b1;
                if (i == LAST_I) state_n = READ_I;
            end
            READ_I: begin
                addr    = i;
                state_n = READ_J;
            end
            READ_J: begin
                // rddata is S[i]; present the new j so S[j] arrives in WRITE_I.
                addr    = j_sum;
                state_n = WRITE_I;
            end
            WRITE_I: begin
                addr    = i;
                wrdata  = rddata;
                wren    = 1'b1;
                state_n = WRITE_J;
            end
            WRITE_J: begin
                addr    = j;
                wrdata  = si;
                wren    = 1'b1;
                state_n = (i == LAST_I) ? IDLE : READ_I;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: drives three engine configurations against behavioural S-box memories
// and compares final memory, latency and write counts with a software RC4 KSA model.
module tb_ksa_engine;

    typedef struct {
        int           w;
        logic [127:0] key;
        bit           skip;
        bit           disturb;
        int           rst_at;
        int           exp_lat;
        bit           chk_const;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic         en_v    [3];
    logic         skip_v  [3];
    logic [127:0] key_v   [3];
    logic         fill_req[3];
    logic         fill_id;

    logic       rdy0, wren0, rdy1, wren1, rdy2, wren2;
    logic [7:0] addr0, wrd0, rd0, addr2, wrd2, rd2;
    logic [3:0] addr1, wrd1, rd1;
    logic [7:0] mem0 [256];
    logic [3:0] mem1 [16];
    logic [7:0] mem2 [256];

    int total = 0;
    int bad   = 0;
    int ref_s [256];

    always #5 clk = ~clk;

    ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) dut0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .skip_init(skip_v[0]), .key(key_v[0][23:0]),
        .rdy(rdy0), .addr(addr0), .rddata(rd0), .wrdata(wrd0), .wren(wren0));

    ksa_engine #(.ADDR_W(4), .KEY_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .skip_init(skip_v[1]), .key(key_v[1][7:0]),
        .rdy(rdy1), .addr(addr1), .rddata(rd1), .wrdata(wrd1), .wren(wren1));

    ksa_engine #(.ADDR_W(8), .KEY_BYTES(16)) dut2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .skip_init(skip_v[2]), .key(key_v[2]),
        .rdy(rdy2), .addr(addr2), .rddata(rd2), .wrdata(wrd2), .wren(wren2));

    // Synchronous-read memories with a bench-controlled bulk fill (identity or scrambled).
    always @(posedge clk) begin
        if (fill_req[0]) for (int k = 0; k < 256; k++) mem0[k] <= fill_id ? 8'(k) : 8'(k*7+3);
        else if (wren0) mem0[addr0] <= wrd0;
        rd0 <= mem0[addr0];
    end

    always @(posedge clk) begin
        if (fill_req[1]) for (int k = 0; k < 16; k++) mem1[k] <= fill_id ? 4'(k) : 4'(k*7+3);
        else if (wren1) mem1[addr1] <= wrd1;
        rd1 <= mem1[addr1];
    end

    always @(posedge clk) begin
        if (fill_req[2]) for (int k = 0; k < 256; k++) mem2[k] <= fill_id ? 8'(k) : 8'(k*7+3);
        else if (wren2) mem2[addr2] <= wrd2;
        rd2 <= mem2[addr2];
    end

    function automatic int get_mem(input int w, input int k);
        case (w)
            0:       return int'(mem0[k]);
            1:       return int'(mem1[k]);
            default: return int'(mem2[k]);
        endcase
    endfunction

    function automatic logic get_rdy(input int w);
        case (w)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_wren(input int w);
        case (w)
            0:       return wren0;
            1:       return wren1;
            default: return wren2;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain RC4 key schedule over an n-entry table with kb key bytes (byte 0 = MSB of the key).
    task automatic ksa_model(input int n, input int kb, input logic [127:0] key);
        int j = 0;
        int t;
        int kbyte;
        for (int k = 0; k < n; k++) ref_s[k] = k;
        for (int i = 0; i < n; i++) begin
            kbyte = int'((key >> (8 * (kb - 1 - (i % kb)))) & 128'hFF);
            j = (j + ref_s[i] + kbyte) % n;
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic run(input vec_t v);
        int  n  = (v.w == 1) ? 16 : 256;
        int  kb = (v.w == 0) ? 3 : ((v.w == 1) ? 1 : 16);
        int  c = 0;
        int  writes = 0;
        int  errs;
        bit  done = 0;
        bit  seen [256];

        @(negedge clk);
        fill_id = v.skip;
        fill_req[v.w] = 1'b1;
        @(negedge clk);
        fill_req[v.w] = 1'b0;
        key_v[v.w]  = v.key;
        skip_v[v.w] = v.skip;
        en_v[v.w]   = 1'b1;
        @(posedge clk);
        #1;
        en_v[v.w] = 1'b0;
        check($sformatf("rdy_drop w%0d", v.w), 64'(get_rdy(v.w)), 64'd0);

        while (!done && c < 4000) begin
            if (get_wren(v.w)) writes++;
            if (!v.skip && c == n) begin
                errs = 0;
                for (int k = 0; k < n; k++) if (get_mem(v.w, k) != k) errs++;
                check($sformatf("init_identity w%0d", v.w), 64'(errs), 64'd0);
            end
            if (v.rst_at != 0 && c == v.rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("abort_rdy", 64'(get_rdy(v.w)), 64'd1);
                check("abort_wren", 64'(get_wren(v.w)), 64'd0);
                check("abort_addr", 64'(addr0), 64'd0);
                check("abort_wrdata", 64'(wrd0), 64'd0);
                return;
            end
            if (v.disturb) begin
                en_v[v.w] = (c % 97 == 5);
                if (c % 53 == 7) key_v[v.w] = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            #1;
            c++;
            if (get_rdy(v.w)) done = 1;
        end
        en_v[v.w] = 1'b0;

        check($sformatf("latency w%0d", v.w), 64'(c), 64'(v.exp_lat));
        check($sformatf("write_count w%0d", v.w), 64'(writes), 64'(v.skip ? 2*n : 3*n));

        ksa_model(n, kb, v.key);
        errs = 0;
        for (int k = 0; k < n; k++) if (get_mem(v.w, k) != ref_s[k]) errs++;
        check($sformatf("mem_vs_model w%0d", v.w), 64'(errs), 64'd0);

        errs = 0;
        for (int k = 0; k < 256; k++) seen[k] = 0;
        for (int k = 0; k < n; k++) begin
            if (seen[get_mem(v.w, k)]) errs++;
            seen[get_mem(v.w, k)] = 1;
        end
        check($sformatf("permutation w%0d", v.w), 64'(errs), 64'd0);

        if (v.chk_const) begin
            check("mem0_const", 64'(get_mem(0, 0)), 64'hB4);
            check("mem255_const", 64'(get_mem(0, 255)), 64'h1B);
        end
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0, 128'h00033C, 0, 0, 0,   1281, 1};
        tbl[1] = '{0, 128'h00033C, 1, 0, 0,   1025, 1};
        tbl[2] = '{0, 128'h00033C, 0, 1, 0,   1281, 1};
        tbl[3] = '{0, 128'h00033C, 0, 0, 600, 1281, 0};
        tbl[4] = '{0, 128'h00033C, 0, 0, 0,   1281, 1};
        tbl[5] = '{0, {104'h0, 24'($urandom)}, 0, 0, 0, 1281, 0};
        tbl[6] = '{1, {120'h0, 8'($urandom)}, 0, 0, 0, 81, 0};
        tbl[7] = '{1, {120'h0, 8'($urandom)}, 1, 0, 0, 65, 0};
        tbl[8] = '{2, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1281, 0};
        tbl[9] = '{2, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 1025, 0};

        rst = 1'b1;
        fill_id = 1'b0;
        for (int w = 0; w < 3; w++) begin
            en_v[w] = 1'b0;
            skip_v[w] = 1'b0;
            key_v[w] = '0;
            fill_req[w] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: outputs quiet for 10 cycles with en low.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("idle_rdy", 64'(rdy0), 64'd1);
            check("idle_wren", 64'(wren0), 64'd0);
            check("idle_addr", 64'(addr0), 64'd0);
            check("idle_wrdata", 64'(wrd0), 64'd0);
        end
        check("idle_rdy1", 64'(rdy1), 64'd1);
        check("idle_rdy2", 64'(rdy2), 64'd1);

        // Reset and en together: reset wins and no run starts.
        @(negedge clk);
        rst = 1'b1;
        en_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en_v[0] = 1'b0;
        check("rst_en_rdy", 64'(rdy0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_rdy_hold", 64'(rdy0), 64'd1);
        check("rst_en_wren", 64'(wren0), 64'd0);

        for (int t = 0; t < 10; t++) run(tbl[t]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
